rom_port_arbiter: RTL and testbench

//  Shares the single combinational read port of rom_256x32 between two requesters:
//   - instruction fetch (IF)
//   - load/store read-only constant loads (LS)

---
 rtl/rom_arb_pkg.sv | 13 +
 rtl/rom_rsp_slot.sv | 30 +++
 rtl/rom_port_arbiter.sv | 94 +++++++++
 tb/tb_rom_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared widths and grant encoding for the ROM read-port arbiter.
package rom_arb_pkg;

    localparam int unsigned ROM_ADDR_W = 8;
    localparam int unsigned ROM_DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } grant_e;

endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry registered response slot with valid/ready drain and a discard input.
module rom_rsp_slot
    import rom_arb_pkg::*;
#(
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    // A new load wins over drain/discard so back-to-back words stream at one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (clr || rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single combinational ROM read port between instruction fetch and LS constant loads.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ROM_ADDR_W,
    parameter int unsigned DATA_W     = ROM_DATA_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    grant_e           gnt;
    logic             elig_if;
    logic             elig_ls;
    logic             both_elig;
    logic             starve_hit;

    // A requester is eligible only if its response slot can take a word this cycle.
    assign elig_if    = if_req_valid && (!if_rsp_valid || if_rsp_ready) && !if_flush;
    assign elig_ls    = ls_req_valid && (!ls_rsp_valid || ls_rsp_ready);
    assign both_elig  = elig_if && elig_ls;
    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

    // LS has priority on contention until IF has lost STARVE_MAX times in a row.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (both_elig) begin
                gnt = starve_hit ? GNT_IF : GNT_LS;
            end else if (elig_if) begin
                gnt = GNT_IF;
            end else if (elig_ls) begin
                gnt = GNT_LS;
            end
        end
    end

    assign if_req_ready = (gnt == GNT_IF);
    assign ls_req_ready = (gnt == GNT_LS);
    assign rom_addr     = (gnt == GNT_LS) ? ls_req_addr : if_req_addr;

    // Counts consecutive contested LS wins; any IF grant restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_IF) begin
            starve_cnt <= '0;
        end else if (both_elig && (gnt == GNT_LS) && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    rom_rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (if_flush),
        .load      (if_req_ready),
        .load_data (rom_data),
        .rsp_valid (if_rsp_valid),
        .rsp_ready (if_rsp_ready),
        .rsp_data  (if_rsp_data)
    );

    rom_rsp_slot #(.DATA_W(DATA_W)) u_ls_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .load      (ls_req_ready),
        .load_data (rom_data),
        .rsp_valid (ls_rsp_valid),
        .rsp_ready (ls_rsp_ready),
        .rsp_data  (ls_rsp_data)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a behavioural ROM and transaction-level model.
module tb_rom_port_arbiter;

    localparam int unsigned STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid, if_rsp_ready;
    logic [7:0]  if_req_addr;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_ready;
    logic [7:0]  ls_req_addr;
    logic [31:0] ls_rsp_data;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;

    int errors = 0;
    int checks = 0;

    // Model state: one entry per response slot plus the count of consecutive contested LS wins.
    logic        m_if_v, m_ls_v;
    logic [31:0] m_if_d, m_ls_d;
    int          m_starve;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_image(input logic [7:0] a);
        if (a == 8'h00) return 32'h0000_0013;
        if (a == 8'h01) return 32'h0010_0093;
        return {a, a, a, a};
    endfunction

    assign rom_data = rom_image(rom_addr);

    rom_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_req_addr  (ls_req_addr),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_ready (ls_rsp_ready),
        .ls_rsp_data  (ls_rsp_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    // Who should be granted this cycle, derived from the arbitration rules.
    task automatic model_grant(output logic gi, output logic gl);
        logic want_if, want_ls;
        want_if = if_req_valid && (!m_if_v || if_rsp_ready) && !if_flush;
        want_ls = ls_req_valid && (!m_ls_v || ls_rsp_ready);
        if (rst) begin
            gi = 1'b0; gl = 1'b0;
        end else if (want_if && want_ls) begin
            gi = (m_starve == int'(STARVE_MAX));
            gl = !gi;
        end else begin
            gi = want_if; gl = want_ls;
        end
    endtask

    // Advance one clock; the model takes the same step as the slots and counter should.
    task automatic tick();
        logic gi, gl, contested;
        logic        n_if_v, n_ls_v;
        logic [31:0] n_if_d, n_ls_d;
        int          n_starve;
        model_grant(gi, gl);
        contested = if_req_valid && (!m_if_v || if_rsp_ready) && !if_flush
                    && ls_req_valid && (!m_ls_v || ls_rsp_ready);
        n_if_d = m_if_d; n_ls_d = m_ls_d; n_starve = m_starve;
        if (rst) begin
            n_if_v = 1'b0; n_ls_v = 1'b0; n_if_d = '0; n_ls_d = '0; n_starve = 0;
        end else begin
            if (gi) begin n_if_v = 1'b1; n_if_d = rom_image(if_req_addr); end
            else n_if_v = m_if_v && !if_rsp_ready && !if_flush;
            if (gl) begin n_ls_v = 1'b1; n_ls_d = rom_image(ls_req_addr); end
            else n_ls_v = m_ls_v && !ls_rsp_ready;
            if (gi) n_starve = 0;
            else if (contested && gl) n_starve = m_starve + 1;
        end
        @(posedge clk);
        #1;
        m_if_v = n_if_v; m_if_d = n_if_d; m_ls_v = n_ls_v; m_ls_d = n_ls_d; m_starve = n_starve;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_req_addr = 8'h00; if_flush = 1'b0; if_rsp_ready = 1'b1;
        ls_req_valid = 1'b0; ls_req_addr = 8'h00; ls_rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: if=%b ls=%b required 0 0", if_req_ready, ls_req_ready);
        end
        tick(); tick();
        checks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0 || ls_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ifv=%b lsv=%b ifd=%h lsd=%h required 0 0 0 0",
                     if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data);
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_if_only();
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 8'h00;
        #1;
        checks++;
        if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL if_only_grant: ready=%b ls=%b addr=%h required 1 0 00", if_req_ready, ls_req_ready, rom_addr);
        end
        tick();
        idle_inputs();
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0000_0013) begin
            errors++;
            $display("FAIL if_only_rsp: v=%b d=%h required 1 00000013", if_rsp_valid, if_rsp_data);
        end
        tick();
    endtask

    // Both contend every cycle starting from a cleared counter: LS,LS,LS,IF repeating.
    task automatic test_starvation();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic exp_if;
            if_req_addr = 8'(8'h20 + i); ls_req_addr = 8'(8'h40 + i);
            exp_if = ((i % 4) == 3);
            #1;
            checks++;
            if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin
                errors++;
                $display("FAIL starve_pattern[%0d]: if=%b ls=%b required %b %b", i, if_req_ready, ls_req_ready, exp_if, !exp_if);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ls_hold();
        idle_inputs();
        ls_req_valid = 1'b1; ls_req_addr = 8'h05; ls_rsp_ready = 1'b0;
        tick();
        if_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_addr = 8'(8'h30 + i);
            #1;
            checks++;
            if (ls_req_ready !== 1'b0 || if_req_ready !== 1'b1 || ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h0505_0505) begin
                errors++;
                $display("FAIL ls_hold[%0d]: lsrdy=%b ifrdy=%b lsv=%b lsd=%h required 0 1 1 05050505",
                         i, ls_req_ready, if_req_ready, ls_rsp_valid, ls_rsp_data);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3] = '{32'h1010_1010, 32'h1111_1111, 32'h1212_1212};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if_req_valid = 1'b1; if_req_addr = 8'(8'h10 + i);
            #1;
            checks++;
            if (if_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, if_req_ready);
            end
            tick();
            checks++;
            if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_rsp[%0d]: v=%b d=%h required 1 %h", i, if_rsp_valid, if_rsp_data, exp_d[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 8'h07; if_rsp_ready = 1'b0;
        tick();
        if_flush = 1'b1; if_req_addr = 8'h08;
        ls_req_valid = 1'b1; ls_req_addr = 8'h09;
        #1;
        checks++;
        if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b1 || if_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: ifrdy=%b lsrdy=%b ifv=%b required 0 1 1", if_req_ready, ls_req_ready, if_rsp_valid);
        end
        tick();
        if_flush = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
        checks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h0909_0909) begin
            errors++;
            $display("FAIL flush_after: ifv=%b lsv=%b lsd=%h required 0 1 09090909", if_rsp_valid, ls_rsp_valid, ls_rsp_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        if_rsp_ready = 1'b0; ls_rsp_ready = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 8'h03;
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 8'h04;
        tick();
        if_req_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 || if_rsp_valid !== 1'b1 || ls_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_cycle: ifrdy=%b lsrdy=%b ifv=%b lsv=%b required 0 0 1 1",
                     if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: ifv=%b lsv=%b required 0 0", if_rsp_valid, ls_rsp_valid);
        end
        if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_if;
            exp_if = (i == 3);
            #1;
            checks++;
            if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin
                errors++;
                $display("FAIL rst_mid_starve[%0d]: if=%b ls=%b required %b %b", i, if_req_ready, ls_req_ready, exp_if, !exp_if);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic gi, gl;
            logic [7:0] exp_addr;
            if_req_valid = 1'($urandom_range(0, 3) != 0);
            ls_req_valid = 1'($urandom_range(0, 3) != 0);
            if_req_addr  = 8'($urandom);
            ls_req_addr  = 8'($urandom);
            if_rsp_ready = 1'($urandom_range(0, 2) != 0);
            ls_rsp_ready = 1'($urandom_range(0, 2) != 0);
            if_flush     = 1'($urandom_range(0, 9) == 0);
            rst          = 1'($urandom_range(0, 99) == 0);
            #1;
            model_grant(gi, gl);
            exp_addr = gl ? ls_req_addr : if_req_addr;
            checks++;
            if (if_req_ready !== gi || ls_req_ready !== gl || rom_addr !== exp_addr) begin
                errors++;
                $display("FAIL rand_grant[%0d]: if=%b ls=%b addr=%h required %b %b %h",
                         i, if_req_ready, ls_req_ready, rom_addr, gi, gl, exp_addr);
            end
            checks++;
            if (if_rsp_valid !== m_if_v || ls_rsp_valid !== m_ls_v
                || (m_if_v && if_rsp_data !== m_if_d) || (m_ls_v && ls_rsp_data !== m_ls_d)) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: ifv=%b ifd=%h lsv=%b lsd=%h required %b %h %b %h",
                         i, if_rsp_valid, if_rsp_data, ls_rsp_valid, ls_rsp_data, m_if_v, m_if_d, m_ls_v, m_ls_d);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        m_if_v = 1'b0; m_ls_v = 1'b0; m_if_d = '0; m_ls_d = '0; m_starve = 0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_if_only();
        test_starvation();
        test_ls_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
